axis_i2s_transmitter: RTL and testbench

AXIS_I2S_TRANSMITTER -- requirements
Module: axis_i2s_transmitter

---
 rtl/axis_i2s_transmitter.sv | 159 +++++++++++++++
 tb/tb_axis_i2s_transmitter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_i2s_transmitter.sv
// AXI-Stream to I2S transmitter: collects a left/right sample pair and serialises it
// MSB-first into two 32-bit slots, generating SCLK and LRCK from the system clock.
module axis_i2s_transmitter #(
  parameter int DATA_WIDTH = 24,
  parameter int SCLK_DIV   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axis_data,
  input  logic        s_axis_valid,
  output logic        s_axis_ready,
  input  logic        s_axis_last,
  output logic        i2s_sclk,
  output logic        i2s_lrck,
  output logic        i2s_sdata,
  output logic        underrun,
  output logic        sync_err
);

  localparam int DivW = $clog2(SCLK_DIV);

  typedef enum logic [1:0] {FILL_L, FILL_R, FULL} state_e;

  state_e                state_q, state_d;
  logic [DivW-1:0]       divCnt_q, divCnt_d;
  logic                  sclk_q, sclk_d;
  logic                  lrck_q, lrck_d;
  logic                  sdata_q, sdata_d;
  logic [5:0]            bitCnt_q, bitCnt_d;
  logic [DATA_WIDTH-1:0] leftHold_q, leftHold_d;
  logic [DATA_WIDTH-1:0] rightHold_q, rightHold_d;
  logic [DATA_WIDTH-1:0] leftShift_q, leftShift_d;
  logic [DATA_WIDTH-1:0] rightShift_q, rightShift_d;
  logic                  underrun_q, underrun_d;
  logic                  syncErr_q, syncErr_d;
  logic                  divTerm, sclkFall, frameStart;
  logic                  loadLeft, loadRight, loadPair, misaligned;

  if (DATA_WIDTH < 32) begin : gUnusedData
    logic unusedBits;
    assign unusedBits = ^s_axis_data[31:DATA_WIDTH];
  end

  assign divTerm    = (divCnt_q == DivW'(SCLK_DIV - 1));
  assign sclkFall   = divTerm && sclk_q;
  assign frameStart = sclkFall && (bitCnt_q == 6'd63);

  always_ff @(posedge clk) begin
    if (reset) state_q <= FILL_L;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL_L:  if (s_axis_valid && !s_axis_last) state_d = FILL_R;
      FILL_R:  if (s_axis_valid && s_axis_last) state_d = FULL;
      FULL:    if (frameStart) state_d = FILL_L;
      default: state_d = FILL_L;
    endcase
  end

  // A pair completed on the frame-start clk is still FILL_R here, so it waits a frame.
  always_comb begin
    s_axis_ready = 1'b1;
    loadLeft     = 1'b0;
    loadRight    = 1'b0;
    loadPair     = 1'b0;
    misaligned   = 1'b0;
    case (state_q)
      FILL_L: begin
        if (s_axis_valid) begin
          if (s_axis_last) misaligned = 1'b1;
          else             loadLeft   = 1'b1;
        end
      end
      FILL_R: begin
        if (s_axis_valid) begin
          if (s_axis_last) begin
            loadRight = 1'b1;
          end else begin
            loadLeft   = 1'b1;
            misaligned = 1'b1;
          end
        end
      end
      FULL: begin
        s_axis_ready = 1'b0;
        loadPair     = frameStart;
      end
      default: s_axis_ready = 1'b0;
    endcase
  end

  always_comb begin
    divCnt_d     = divTerm ? '0 : divCnt_q + 1'b1;
    sclk_d       = divTerm ? ~sclk_q : sclk_q;
    bitCnt_d     = sclkFall ? bitCnt_q + 6'd1 : bitCnt_q;
    lrck_d       = bitCnt_d[5];
    leftHold_d   = loadLeft ? s_axis_data[DATA_WIDTH-1:0] : leftHold_q;
    rightHold_d  = loadRight ? s_axis_data[DATA_WIDTH-1:0] : rightHold_q;
    underrun_d   = frameStart && (state_q != FULL);
    syncErr_d    = misaligned;
    sdata_d      = sdata_q;
    leftShift_d  = leftShift_q;
    rightShift_d = rightShift_q;
    // Zero-fill shifting yields the trailing zero bits of each slot for free.
    if (sclkFall) begin
      if (frameStart) begin
        sdata_d      = 1'b0;
        leftShift_d  = loadPair ? leftHold_q : '0;
        rightShift_d = loadPair ? rightHold_q : '0;
      end else if (bitCnt_d[4:0] == 5'd0) begin
        sdata_d = 1'b0;
      end else if (!bitCnt_d[5]) begin
        sdata_d     = leftShift_q[DATA_WIDTH-1];
        leftShift_d = leftShift_q << 1;
      end else begin
        sdata_d      = rightShift_q[DATA_WIDTH-1];
        rightShift_d = rightShift_q << 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      divCnt_q     <= '0;
      sclk_q       <= 1'b0;
      lrck_q       <= 1'b0;
      sdata_q      <= 1'b0;
      bitCnt_q     <= '0;
      leftHold_q   <= '0;
      rightHold_q  <= '0;
      leftShift_q  <= '0;
      rightShift_q <= '0;
      underrun_q   <= 1'b0;
      syncErr_q    <= 1'b0;
    end else begin
      divCnt_q     <= divCnt_d;
      sclk_q       <= sclk_d;
      lrck_q       <= lrck_d;
      sdata_q      <= sdata_d;
      bitCnt_q     <= bitCnt_d;
      leftHold_q   <= leftHold_d;
      rightHold_q  <= rightHold_d;
      leftShift_q  <= leftShift_d;
      rightShift_q <= rightShift_d;
      underrun_q   <= underrun_d;
      syncErr_q    <= syncErr_d;
    end
  end

  assign i2s_sclk  = sclk_q;
  assign i2s_lrck  = lrck_q;
  assign i2s_sdata = sdata_q;
  assign underrun  = underrun_q;
  assign sync_err  = syncErr_q;

endmodule

// File: tb/tb_axis_i2s_transmitter.sv
// Self-checking bench for axis_i2s_transmitter: a cycle-level reference model derived
// from frame timing arithmetic, plus table-driven beats and directed frame captures.
module tb_axis_i2s_transmitter;

  localparam int DW    = 24;
  localparam int SD    = 4;
  localparam int FRAME = 128 * SD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_axis_data = '0;
  logic        s_axis_valid = 1'b0;
  logic        s_axis_last = 1'b0;
  logic        s_axis_ready;
  logic        i2s_sclk, i2s_lrck, i2s_sdata, underrun, sync_err;

  axis_i2s_transmitter #(.DATA_WIDTH(DW), .SCLK_DIV(SD)) dut (
    .clk(clk), .reset(reset),
    .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid),
    .s_axis_ready(s_axis_ready), .s_axis_last(s_axis_last),
    .i2s_sclk(i2s_sclk), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata),
    .underrun(underrun), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Reference model: time since reset fixes SCLK/LRCK/bit position; pairs are tracked as values.
  int                cyc = 0;
  bit                haveLeft = 0, pairReady = 0, expUnd = 0, expSync = 0;
  logic [DW-1:0]     leftVal = '0, pairL = '0, pairR = '0, playL = '0, playR = '0;

  always @(posedge clk) begin : scoreboard
    bit            r, v, l, fs, rdyBefore;
    logic [31:0]   d;
    int            bc, k;
    logic [DW-1:0] smp;
    logic          sd;
    logic [5:0]    expVec, actVec;
    r = reset; v = s_axis_valid; l = s_axis_last; d = s_axis_data;
    if (r) begin
      cyc = 0; haveLeft = 0; pairReady = 0; leftVal = '0;
      playL = '0; playR = '0; expUnd = 0; expSync = 0;
    end else begin
      cyc++;
      fs        = (cyc % FRAME) == 0;
      rdyBefore = !pairReady;
      expUnd    = fs && !pairReady;
      if (fs) begin
        if (pairReady) begin playL = pairL; playR = pairR; pairReady = 0; end
        else begin playL = '0; playR = '0; end
      end
      expSync = 0;
      if (v && rdyBefore) begin
        if (!haveLeft) begin
          if (!l) begin leftVal = d[DW-1:0]; haveLeft = 1; end
          else expSync = 1;
        end else if (l) begin
          pairL = leftVal; pairR = d[DW-1:0]; pairReady = 1; haveLeft = 0;
        end else begin
          leftVal = d[DW-1:0]; expSync = 1;
        end
      end
    end
    #1;
    bc  = (cyc / (2 * SD)) % 64;
    k   = bc % 32;
    smp = (bc < 32) ? playL : playR;
    sd  = (k >= 1 && k <= DW) ? smp[DW-k] : 1'b0;
    expVec = {((cyc / SD) % 2) == 1, bc >= 32, sd, !pairReady, expUnd, expSync};
    actVec = {i2s_sclk, i2s_lrck, i2s_sdata, s_axis_ready, underrun, sync_err};
    checkOutput($sformatf("cycle %0d {sclk,lrck,sdata,ready,underrun,sync_err}", cyc), 64'(actVec), 64'(expVec));
  end

  task automatic applyStimulus(input logic [31:0] data, input logic lastIn, output bit accepted, output int stallCycles);
    bit rdy;
    accepted = 0; stallCycles = 0;
    @(negedge clk);
    s_axis_data = data; s_axis_last = lastIn; s_axis_valid = 1'b1;
    for (int i = 0; i < 4 * FRAME && !accepted; i++) begin
      rdy = s_axis_ready;
      @(posedge clk);
      if (rdy) accepted = 1;
      else begin stallCycles++; @(negedge clk); end
    end
    checkOutput("beat_accepted", 64'(accepted), 64'd1);
  endtask

  task automatic idleInputs();
    @(negedge clk);
    s_axis_valid = 1'b0;
  endtask

  task automatic waitCycMod(input int target);
    bit found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if ((cyc % FRAME) == target) found = 1;
    end
    checkOutput("wait_cycle_reached", 64'(found), 64'd1);
  endtask

  // Captures bit counts 0..63 of the next frame, sampling SDATA on SCLK rising edges.
  task automatic captureFrame(output logic [63:0] frameBits);
    logic prevL, prevS;
    bit   found = 0;
    int   n = 0;
    frameBits = '0;
    @(negedge clk);
    prevL = i2s_lrck;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      @(negedge clk);
      if (prevL && !i2s_lrck) found = 1;
      prevL = i2s_lrck;
    end
    checkOutput("frame_start_seen", 64'(found), 64'd1);
    prevS = i2s_sclk;
    for (int i = 0; i < 2 * FRAME && n < 64; i++) begin
      @(negedge clk);
      if (!prevS && i2s_sclk) begin frameBits[63-n] = i2s_sdata; n++; end
      prevS = i2s_sclk;
    end
    checkOutput("frame_bits_captured", 64'(n), 64'd64);
  endtask

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        expSync;
    logic        expReady;
  } vec_t;

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    vec_t        vecs[6];
    logic [63:0] fb;
    logic [31:0] dl, dr;
    logic        prevS;
    bit          acc;
    int          stall, totalStall, und, ones, period, rises;

    vecs[0] = '{32'hFF111111, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{32'h00222222, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{32'hAB333333, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{32'h00444444, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'h00555555, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{32'h12666666, 1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    checkOutput("reset_state", 64'({i2s_sclk, i2s_lrck, i2s_sdata, s_axis_ready, underrun, sync_err}), 64'b000100);
    reset = 1'b0;

    // Basic transfer and SCLK period
    applyStimulus(32'h00ABCDEF, 1'b0, acc, stall);
    applyStimulus(32'h00123456, 1'b1, acc, stall);
    idleInputs();
    prevS = i2s_sclk; period = 0; rises = 0;
    for (int i = 0; i < 4 * SD * 4 && rises < 2; i++) begin
      @(negedge clk);
      if (rises == 1) period++;
      if (!prevS && i2s_sclk) rises++;
      prevS = i2s_sclk;
    end
    checkOutput("sclk_period", 64'(period), 64'(2 * SD));
    captureFrame(fb);
    checkOutput("basic_left_slot", fb[63:32], {32'h0, 1'b0, 24'hABCDEF, 7'b0});
    checkOutput("basic_right_slot", fb[31:0], {32'h0, 1'b0, 24'h123456, 7'b0});

    // Two idle frames
    und = 0; ones = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      und += int'(underrun); ones += int'(i2s_sdata);
    end
    checkOutput("idle_underrun_pulses", 64'(und), 64'd2);
    checkOutput("idle_sdata_ones", 64'(ones), 64'd0);

    // Misaligned and overwriting beats
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].data, vecs[i].last, acc, stall);
      #1;
      checkOutput($sformatf("vec%0d_sync_err", i), 64'(sync_err), 64'(vecs[i].expSync));
      checkOutput($sformatf("vec%0d_ready", i), 64'(s_axis_ready), 64'(vecs[i].expReady));
    end
    idleInputs();
    captureFrame(fb);
    checkOutput("realigned_left_slot", fb[63:32], {32'h0, 1'b0, 24'h555555, 7'b0});
    checkOutput("realigned_right_slot", fb[31:0], {32'h0, 1'b0, 24'h666666, 7'b0});

    // Continuous stream of three pairs
    totalStall = 0; dl = '0; dr = '0;
    for (int p = 0; p < 3; p++) begin
      dl = $urandom; dr = $urandom;
      applyStimulus(dl, 1'b0, acc, stall); totalStall += stall;
      applyStimulus(dr, 1'b1, acc, stall); totalStall += stall;
      #1;
      checkOutput($sformatf("stream_pair%0d_ready_low", p), 64'(s_axis_ready), 64'd0);
    end
    idleInputs();
    checkOutput("stream_stalled", 64'(totalStall > 0), 64'd1);
    captureFrame(fb);
    checkOutput("stream_last_left", fb[63:32], {32'h0, 1'b0, dl[DW-1:0], 7'b0});
    checkOutput("stream_last_right", fb[31:0], {32'h0, 1'b0, dr[DW-1:0], 7'b0});

    // Pair completes on the frame-start clk
    dl = $urandom; dr = $urandom;
    waitCycMod(100);
    applyStimulus(dl, 1'b0, acc, stall);
    idleInputs();
    waitCycMod(FRAME - 2);
    applyStimulus(dr, 1'b1, acc, stall);
    #1;
    checkOutput("collision_underrun", 64'(underrun), 64'd1);
    checkOutput("collision_ready", 64'(s_axis_ready), 64'd0);
    idleInputs();
    captureFrame(fb);
    checkOutput("collision_left_next", fb[63:32], {32'h0, 1'b0, dl[DW-1:0], 7'b0});
    checkOutput("collision_right_next", fb[31:0], {32'h0, 1'b0, dr[DW-1:0], 7'b0});

    // Reset at bit count 40 with a left sample pending
    waitCycMod(300);
    applyStimulus(32'h00DEAD5A, 1'b0, acc, stall);
    idleInputs();
    waitCycMod(320);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset_outputs", 64'({i2s_sclk, i2s_lrck, i2s_sdata, s_axis_ready, underrun, sync_err}), 64'b000100);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(32'h00777777, 1'b1, acc, stall);
    #1;
    checkOutput("postreset_sync_err", 64'(sync_err), 64'd1);
    idleInputs();
    und = 0; ones = 0;
    repeat (FRAME + 100) begin
      @(negedge clk);
      und += int'(underrun); ones += int'(i2s_sdata);
    end
    checkOutput("postreset_underrun_pulses", 64'(und), 64'd1);
    checkOutput("postreset_sdata_ones", 64'(ones), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
